// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and latency constants for the HI/LO multiply/divide unit.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO registers and MTHI/MTLO writes.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   state  = S_IDLE;
  md_op_e      op_q   = OP_NOP;
  logic [3:0]  cnt    = '0;
  logic [31:0] a_q    = '0;
  logic [31:0] b_q    = '0;
  logic [31:0] hi_q   = '0;
  logic [31:0] lo_q   = '0;
  logic        busy_q = 1'b0;

  md_op_e             op_in;
  logic               issue;
  logic [3:0]         term;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  assign op_in  = md_op_e'(MDOp);
  assign issue  = Start && !Req && !busy_q && (op_in != OP_NOP) && (op_in != OP_NOP7);
  assign term   = (state == S_MUL) ? (MUL_LAT - 4'd1) : (DIV_LAT - 4'd1);

  // Full-width results always come from the latched operands, never from A/B.
  assign prod_s  = $signed(a_q) * $signed(b_q);
  assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_ovf) begin
          res_lo = 32'h8000_0000;
          res_hi = '0;
        end else if (b_q != '0) begin
          res_lo = $signed(a_q) / $signed(b_q);
          res_hi = $signed(a_q) % $signed(b_q);
        end
      end
      OP_DIVU: begin
        if (b_q != '0) begin
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      cnt    <= '0;
      op_q   <= OP_NOP;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            case (op_in)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state  <= (op_in == OP_MULT || op_in == OP_MULTU) ? S_MUL : S_DIV;
                busy_q <= 1'b1;
                cnt    <= '0;
                op_q   <= op_in;
                a_q    <= A;
                b_q    <= B;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          // The issuing instruction has committed, so Req cannot abort it here.
          if (cnt == term) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            if (state == S_MUL || b_q != '0) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: scoreboard of expected HI/LO checked when Busy falls.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic        Req = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Start(Start),
    .MDOp (MDOp),
    .Req  (Req),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
  endtask

  task automatic idle_inputs();
    Start = 1'b0;
    Req   = 1'b0;
    MDOp  = 3'd0;
    A     = 32'hA5A5_A5A5;
    B     = 32'h5A5A_5A5A;
  endtask

  // Count cycles with Busy high (bounded), then compare HI/LO with the scoreboard head.
  task automatic finish_op(input string tag, input int lat, input int already);
    exp_t e;
    int   n;
    n = already;
    while (Busy && n < 40) begin
      check({tag, "_hold_hi"}, HI, m_hi);
      cycle();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, HI, e.hi);
      check({tag, "_lo"}, LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    exp_q.push_back(e);
    drive(op, a, b);
    cycle();
    idle_inputs();
    check({tag, "_busy_rise"}, 32'(Busy), 32'd1);
    finish_op(tag, lat, 0);
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a);
    drive(op, a, 32'd0);
    cycle();
    idle_inputs();
    if (op == OP_MTHI) m_hi = a;
    else m_lo = a;
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_hi"}, HI, m_hi);
    check({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    exp_t e;
    int   n;

    #1;
    check("init_busy", 32'(Busy), 32'd0);
    check("init_hi", HI, 32'd0);

    Rst = 1'b1;
    cycle();
    cycle();
    Rst = 1'b0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    run_op("mult_neg", OP_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);

    move_to("mthi", OP_MTHI, 32'h11);
    move_to("mtlo", OP_MTLO, 32'h22);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 10);

    // MTHI during a multiply (plain, then with Req) must be dropped; A/B churn is ignored.
    e.hi = 32'h1;
    e.lo = 32'h0;
    exp_q.push_back(e);
    drive(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    cycle();
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'h1234_5678);
    cycle();
    check("busy_mthi_hi", HI, 32'h11);
    Req = 1'b1;
    cycle();
    check("busy_req_hi", HI, 32'h11);
    check("busy_req_busy", 32'(Busy), 32'd1);
    idle_inputs();
    finish_op("mult_req", 5, 2);

    // Start on the falling-Busy edge is ignored; the following cycle's issue is taken.
    e.hi = 32'h0;
    e.lo = 32'h6;
    exp_q.push_back(e);
    drive(OP_MULTU, 32'd2, 32'd3);
    cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle();
    check("edge_busy_before", 32'(Busy), 32'd1);
    drive(OP_MTLO, 32'h55, 32'd0);
    cycle();
    idle_inputs();
    finish_op("mul_edge", 0, 0);
    check("edge_busy_after", 32'(Busy), 32'd0);
    move_to("mtlo_late", OP_MTLO, 32'h55);

    // Reset in cycle 4 of a divide: flush scoreboard, HI/LO clear and stay clear.
    drive(OP_DIV, 32'd100, 32'd3);
    cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    check("div_rst_busy_pre", 32'(Busy), 32'd1);
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("div_rst_busy", 32'(Busy), 32'd0);
    check("div_rst_hi", HI, 32'd0);
    check("div_rst_lo", LO, 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) n++;
    end
    check("div_rst_no_write", 32'(n), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
